// File: rtl/timer_apb_sequencer.sv
// APB master that programs a timer (clear, prescaler, reload, enable), polls TCNT
// until it reaches a threshold, then stops the timer. Includes timeout, poll-limit and abort handling.
module timer_apb_sequencer #(
    parameter int unsigned XFER_TIMEOUT = 16,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned MAX_POLLS    = 1024
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] cfg_psc_i,
    input  logic [31:0] cfg_arr_i,
    input  logic [31:0] cfg_target_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] last_cnt_o,
    output logic [3:0]  PADDR_o,
    output logic [31:0] PWDATA_o,
    output logic        PWRITE_o,
    output logic        PSEL_o,
    output logic        PENABLE_o,
    input  logic [31:0] PRDATA_i,
    input  logic        PREADY_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(4'h0);
    localparam logic [ADDR_W-1:0] ADDR_TCNT = ADDR_W'(4'h4);
    localparam logic [ADDR_W-1:0] ADDR_PSC  = ADDR_W'(4'h8);
    localparam logic [ADDR_W-1:0] ADDR_ARR  = ADDR_W'(4'hC);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((XFER_TIMEOUT > 0) ? XFER_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((POLL_GAP > 1) ? POLL_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] POLL_LIMIT   = CNT_W'(MAX_POLLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        STEP_TCR_CLR,
        STEP_PSC,
        STEP_ARR,
        STEP_TCR_EN,
        STEP_POLL,
        STEP_TCR_OFF
    } step_t;

    state_t              state_q, state_d;
    step_t               step_q, step_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
    logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                abort_pend_q, abort_pend_d;
    logic [DATA_W-1:0]   psc_q, psc_d;
    logic [DATA_W-1:0]   arr_q, arr_d;
    logic [DATA_W-1:0]   target_q, target_d;
    logic [DATA_W-1:0]   last_cnt_q, last_cnt_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;

    logic                abort_eff;
    logic [CNT_W-1:0]    poll_inc;

    // State and registered outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            step_q       <= STEP_TCR_CLR;
            acc_cnt_q    <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            psc_q        <= '0;
            arr_q        <= '0;
            target_q     <= '0;
            last_cnt_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            acc_cnt_q    <= acc_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            abort_pend_q <= abort_pend_d;
            psc_q        <= psc_d;
            arr_q        <= arr_d;
            target_q     <= target_d;
            last_cnt_q   <= last_cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        acc_cnt_d    = acc_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        abort_pend_d = abort_pend_q;
        psc_d        = psc_q;
        arr_d        = arr_q;
        target_d     = target_q;
        last_cnt_d   = last_cnt_q;
        err_d        = err_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        abort_eff    = abort_pend_q | abort_i;
        poll_inc     = poll_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_i) begin
                    psc_d      = cfg_psc_i;
                    arr_d      = cfg_arr_i;
                    target_d   = cfg_target_i;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    step_d     = STEP_TCR_CLR;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                acc_cnt_d = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY_i) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    case (step_q)
                        STEP_TCR_CLR: step_d = abort_eff ? STEP_TCR_OFF : STEP_PSC;
                        STEP_PSC:     step_d = abort_eff ? STEP_TCR_OFF : STEP_ARR;
                        STEP_ARR:     step_d = abort_eff ? STEP_TCR_OFF : STEP_TCR_EN;
                        STEP_TCR_EN:  step_d = abort_eff ? STEP_TCR_OFF : STEP_POLL;
                        STEP_POLL: begin
                            last_cnt_d = PRDATA_i;
                            poll_cnt_d = poll_inc;
                            if (abort_eff || (PRDATA_i >= target_q)) begin
                                step_d = STEP_TCR_OFF;
                            end else if (poll_inc >= POLL_LIMIT) begin
                                state_d = ST_ERR;
                            end else begin
                                gap_cnt_d = GAP_LOAD;
                            end
                        end
                        STEP_TCR_OFF: state_d = ST_DONE;
                        default:      state_d = ST_ERR;
                    endcase
                end else if (acc_cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // An abort seen between transfers redirects straight to the timer stop
                if (abort_eff && (step_q != STEP_TCR_OFF)) begin
                    step_d  = STEP_TCR_OFF;
                    state_d = ST_SETUP;
                end else if (gap_cnt_q == '0) begin
                    state_d = ST_SETUP;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (step_q != STEP_TCR_OFF) && abort_i) begin
            abort_pend_d = 1'b1;
        end

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end

        // Address and data are loaded entering SETUP and held through ACCESS
        if (state_d == ST_SETUP) begin
            case (step_d)
                STEP_TCR_CLR: begin paddr_d = ADDR_TCR;  pwrite_d = 1'b1; pwdata_d = DATA_W'(32'h2); end
                STEP_PSC:     begin paddr_d = ADDR_PSC;  pwrite_d = 1'b1; pwdata_d = psc_q;          end
                STEP_ARR:     begin paddr_d = ADDR_ARR;  pwrite_d = 1'b1; pwdata_d = arr_q;          end
                STEP_TCR_EN:  begin paddr_d = ADDR_TCR;  pwrite_d = 1'b1; pwdata_d = DATA_W'(32'h1); end
                STEP_POLL:    begin paddr_d = ADDR_TCNT; pwrite_d = 1'b0; pwdata_d = '0;             end
                STEP_TCR_OFF: begin paddr_d = ADDR_TCR;  pwrite_d = 1'b1; pwdata_d = '0;             end
                default:      begin paddr_d = ADDR_TCR;  pwrite_d = 1'b0; pwdata_d = '0;             end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign last_cnt_o = last_cnt_q;
    assign PADDR_o    = paddr_q;
    assign PWDATA_o   = pwdata_q;
    assign PWRITE_o   = pwrite_q;
    assign PSEL_o     = psel_q;
    assign PENABLE_o  = penable_q;

endmodule

// File: doc/timer_apb_sequencer.md
TIMER_APB_SEQUENCER -- requirements
Module: timer_apb_sequencer

Interface
REQ-001 SHALL have parameter XFER_TIMEOUT, default 16: maximum ACCESS cycles per APB transfer before an error is raised.
REQ-002 SHALL have parameter POLL_GAP, default 4: idle cycles between consecutive TCNT poll reads.
REQ-003 SHALL have parameter MAX_POLLS, default 1024: maximum TCNT reads before an error is raised.
REQ-004 PCLK  in  1  clock; all logic SHALL be clocked on the rising edge of PCLK.
REQ-005 PRESET  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  sequence request; sampled only in IDLE.
REQ-007 abort  in  1  request an early stop of a running sequence.
REQ-008 cfg_psc, cfg_arr, cfg_target  in  32 each  prescaler value, auto-reload value and poll threshold.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when a sequence completes without error.
REQ-011 err  out  1  sticky error flag; cleared on the next accepted start.
REQ-012 last_cnt  out  32  last TCNT value read over APB.
REQ-013 APB master ports: PADDR out 4, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1, PRDATA in 32, PREADY in 1.

Function
REQ-014 Target timer register map SHALL be: 0x0 TCR (bit1 clear, bit0 enable), 0x4 TCNT (read-only), 0x8 PSC, 0xC ARR.
REQ-015 Accepted start (IDLE, start=1) SHALL latch cfg_psc, cfg_arr and cfg_target, clear err, and enter SETUP for step 0 on the next cycle.
REQ-016 Step order SHALL be fixed:
- S0 write TCR=0x2
- S1 write PSC=cfg_psc
- S2 write ARR=cfg_arr
- S3 write TCR=0x1
- S4 poll read TCNT
- S5 write TCR=0x0
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, GAP, DONE, ERR.
REQ-018 SETUP SHALL last exactly 1 cycle with PSEL=1 and PENABLE=0, and PADDR, PWRITE and PWDATA valid.
REQ-019 ACCESS SHALL drive PSEL=1 and PENABLE=1 with address and data held stable until PREADY=1 is sampled.
REQ-020 The transfer SHALL complete on the edge where PREADY=1 is sampled in ACCESS.
REQ-021 PSEL and PENABLE SHALL be 0 in the cycle after transfer completion.
REQ-022 Each completed transfer SHALL be followed by 1 cycle with PSEL=0 before the next SETUP.
REQ-023 On S4 completion, PRDATA SHALL be loaded into last_cnt.
REQ-024 Poll exit: if PRDATA >= cfg_target (unsigned), the sequence SHALL advance to S5.
REQ-025 Poll repeat: otherwise the block SHALL wait POLL_GAP cycles in GAP with PSEL=0, then repeat S4.
REQ-026 A 32-bit ACCESS-cycle counter SHALL reset at each SETUP.
REQ-027 If XFER_TIMEOUT ACCESS cycles elapse without PREADY=1, the block SHALL enter ERR.
REQ-028 A poll counter SHALL reset at accepted start and increment at each S4 completion.
REQ-029 If the poll counter reaches MAX_POLLS without the exit condition, the block SHALL enter ERR; S5 is not issued.
REQ-030 An in-flight transfer SHALL always complete (or time out) before abort is acted on.
REQ-031 abort=1 in steps S0-S4 SHALL cause a jump to S5 at the next transfer boundary or GAP cycle.
REQ-032 abort=1 during S5 SHALL be ignored.
REQ-033 A sequence ended by abort SHALL still pulse done; err SHALL stay 0.
REQ-034 On S5 completion, the block SHALL enter DONE: done=1 for 1 cycle, then IDLE.
REQ-035 ERR SHALL last 1 cycle with PSEL=0 and PENABLE=0, set err=1, then return to IDLE.
REQ-036 start while busy=1 SHALL be ignored; start and abort in IDLE together SHALL be treated as start only.
REQ-037 cfg_* changes after acceptance SHALL have no effect until the next accepted start.
REQ-038 The threshold comparison SHALL be full 32-bit unsigned; cfg_target=0 SHALL exit after the first poll.

Reset
REQ-039 PRESET=1 SHALL immediately force IDLE with PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0, done=0, err=0, last_cnt=0 and all counters 0.
REQ-040 PRESET asserted mid-transfer SHALL abandon the transfer without completing it; the first start after release SHALL be accepted normally.

Verification
REQ-041 Nominal: start with psc=9, arr=100, target=20, slave PREADY 1 cycle after PENABLE -> APB writes 0x0=2, 0x8=9, 0xC=100, 0x0=1; polls until TCNT>=20; write 0x0=0; done pulse; err=0; last_cnt>=20.
REQ-042 Timeout: PREADY held 0 during S1 -> ERR exactly 16 ACCESS cycles after SETUP; err=1; busy=0; PSEL=0; no further transfers.
REQ-043 Unreachable target: arr=5, target=10, MAX_POLLS=8 -> exactly 8 TCNT reads with POLL_GAP=4 idle cycles between them; err=1; no TCR=0 write.
REQ-044 Abort: abort pulsed while in GAP after the 3rd poll -> next transfer is write 0x0=0; done=1; err=0.
REQ-045 Reset: PRESET asserted during ACCESS of S2 -> all outputs 0 in the same cycle; a fresh start runs the full S0-S5 sequence.
REQ-046 Busy start: start pulsed during S3 -> no latch of new cfg_*; the sequence is unchanged.
